// File: rtl/encoder_8x3_queue_if.sv
// Request/index handshake bundle for encoder_8x3_queue.
// The master drives requests and ready; the slave (encoder) drives the index, valid, pend and empty signals.
interface encoder_8x3_queue_if;
  logic       en;
  logic [7:0] d;
  logic       load;
  logic [2:0] y;
  logic       valid;
  logic       ready;
  logic [7:0] pend;
  logic       empty;

  modport master (
    output en, d, load, ready,
    input  y, valid, pend, empty
  );

  modport slave (
    input  en, d, load, ready,
    output y, valid, pend, empty
  );
endinterface

// File: rtl/encoder_8x3_queue.sv
// Sequential 8-to-3 encoder: queues request lines and presents their indices over valid/ready.
// Fixed highest-index-first priority; define ENCODER_RR_EN for round-robin order.
module encoder_8x3_queue (
  input  logic                 clk,
  input  logic                 rst,
  encoder_8x3_queue_if.slave   bus
);

  logic [7:0] r_pend;
  logic [2:0] r_y;
  logic       r_valid;
`ifdef ENCODER_RR_EN
  logic [2:0] r_last;
`endif

  logic [7:0] w_next_set;
  logic       w_slot_free;
  logic       w_any;
  logic [2:0] w_sel;
  logic [7:0] w_sel_mask;

  assign w_next_set  = r_pend | ((bus.load && bus.en) ? bus.d : '0);
  assign w_slot_free = !r_valid || bus.ready;
  assign w_any       = |w_next_set;

`ifdef ENCODER_RR_EN
  // Search starts just below the last winner and wraps, so the last winner is tried last.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    w_sel = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = r_last - 3'(k);
      if (!found && w_next_set[idx]) begin
        w_sel = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (w_next_set[k]) w_sel = 3'(k);
    end
  end
`endif

  assign w_sel_mask = 8'b1 << w_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
`ifdef ENCODER_RR_EN
      r_last  <= '0;
`endif
    end else if (bus.en) begin
      if (w_slot_free) begin
        if (w_any) begin
          r_y     <= w_sel;
          r_valid <= 1'b1;
          r_pend  <= w_next_set & ~w_sel_mask;
`ifdef ENCODER_RR_EN
          r_last  <= w_sel;
`endif
        end else begin
          r_valid <= 1'b0;
          r_pend  <= '0;
        end
      end else begin
        r_pend <= w_next_set;
      end
    end else if (r_valid && bus.ready) begin
      // Disabled: a pending handshake still completes, but nothing new is selected.
      r_valid <= 1'b0;
    end
  end

  assign bus.y     = r_y;
  assign bus.valid = r_valid;
  assign bus.pend  = r_pend;
  assign bus.empty = (r_pend == '0) && !r_valid;

endmodule

// File: tb/tb_encoder_8x3_queue.sv
// Scoreboard bench for encoder_8x3_queue: driver updates a set-based reference model, monitor checks.
// Honours ENCODER_RR_EN so the model matches the build's selection order.
module tb_encoder_8x3_queue;
  logic clk = 1'b0;
  logic rst;
  encoder_8x3_queue_if bus();

  encoder_8x3_queue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests as a set of flags, presented index or -1.
  bit   m_set[8];
  int   m_cur = -1;
  int   m_y = 0;
`ifdef ENCODER_RR_EN
  int   m_last = 0;
`endif
  int          idxq[$];
  logic [12:0] stq[$];

  function automatic int pick(input bit ns[8]);
`ifdef ENCODER_RR_EN
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (m_last - k + 8) % 8;
      if (ns[i]) return i;
    end
`else
    for (int i = 7; i >= 0; i--) if (ns[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit l, input logic [7:0] dd, input bit rd);
    bit ns[8];
    int s;
    if (r) begin
      foreach (m_set[i]) m_set[i] = 1'b0;
      m_cur = -1;
      m_y = 0;
`ifdef ENCODER_RR_EN
      m_last = 0;
`endif
      idxq.delete();
    end else if (e) begin
      foreach (ns[i]) ns[i] = m_set[i] || (l && dd[i]);
      if (m_cur < 0 || rd) begin
        s = pick(ns);
        if (s >= 0) begin
          ns[s] = 1'b0;
          m_cur = s;
          m_y = s;
`ifdef ENCODER_RR_EN
          m_last = s;
`endif
          idxq.push_back(s);
        end else begin
          m_cur = -1;
        end
      end
      m_set = ns;
    end else if (m_cur >= 0 && rd) begin
      m_cur = -1;
    end
  endtask

  task automatic push_state();
    logic [7:0] pv;
    bit         v;
    foreach (m_set[i]) pv[i] = m_set[i];
    v = (m_cur >= 0);
    stq.push_back({v, 3'(m_y), pv, (pv == 8'h00) && !v});
  endtask

  task automatic step(input bit r, input bit e, input bit l, input logic [7:0] dd, input bit rd);
    rst = r; bus.en = e; bus.load = l; bus.d = dd; bus.ready = rd;
    @(posedge clk);
    #1;
    model_edge(r, e, l, dd, rd);
    push_state();
  endtask

  // Monitor: outputs of the previous edge against the model, plus each accepted index.
  always @(negedge clk) begin
    logic [12:0] exp_s, act_s;
    int e_idx;
    if (stq.size() > 0) begin
      exp_s = stq.pop_front();
      act_s = {bus.valid, bus.y, bus.pend, bus.empty};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL state t=%0t act valid=%b y=%0d pend=%h empty=%b req valid=%b y=%0d pend=%h empty=%b",
                 $time, act_s[12], act_s[11:9], act_s[8:1], act_s[0],
                 exp_s[12], exp_s[11:9], exp_s[8:1], exp_s[0]);
      end
    end
    if (rst === 1'b0 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
      checks++;
      if (idxq.size() == 0) begin
        errors++;
        $display("FAIL accept t=%0t act y=%0d req none", $time, bus.y);
      end else begin
        e_idx = idxq.pop_front();
        if (bus.y !== 3'(e_idx)) begin
          errors++;
          $display("FAIL accept t=%0t act y=%0d req y=%0d", $time, bus.y, e_idx);
        end
      end
    end
  end

  initial begin
    // Reset with load/handshake active
    step(1, 1, 1, 8'hFF, 1);
    step(1, 1, 1, 8'hFF, 1);
    step(0, 1, 0, 8'h00, 1);
    // Single request
    step(0, 1, 1, 8'h08, 1);
    repeat (2) step(0, 1, 0, 8'h00, 1);
    // Multi-request drain
    step(0, 1, 1, 8'h95, 1);
    repeat (5) step(0, 1, 0, 8'h00, 1);
    // Backpressure
    step(0, 1, 1, 8'h03, 0);
    repeat (5) step(0, 1, 0, 8'h00, 0);
    repeat (3) step(0, 1, 0, 8'h00, 1);
    // Enable gating
    repeat (2) step(0, 0, 1, 8'hFF, 1);
    step(0, 1, 1, 8'h80, 0);
    step(0, 0, 0, 8'h00, 1);
    repeat (2) step(0, 1, 0, 8'h00, 1);
    // Zero load is a no-op
    step(0, 1, 1, 8'h00, 1);
    // Accept and re-queue of the presented index at the same edge
    step(0, 1, 1, 8'h81, 1);
    step(0, 1, 1, 8'h80, 1);
    repeat (4) step(0, 1, 0, 8'h00, 1);
    // Reset mid-transfer
    step(0, 1, 1, 8'hFF, 0);
    step(1, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 1);
    // Full load, reload while the third index is accepted
    step(0, 1, 1, 8'hFF, 1);
    repeat (2) step(0, 1, 0, 8'h00, 1);
    step(0, 1, 1, 8'hFF, 1);
    repeat (12) step(0, 1, 0, 8'h00, 1);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (8) step(0, 1, 0, 8'h00, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
